// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : Run/stall handshake bundle between the execute stage and the
//                iterative divider. The core side (master) drives the request
//                and operands and the divider side (slave) returns stall and
//                the registered quotient/remainder.
//  Signals     : run   - divide request, held while the instruction executes
//                u     - 1 = unsigned, 0 = signed dividend
//                x     - dividend
//                y     - divisor (unsigned magnitude)
//                stall - high while a requested result is not yet valid
//                q     - quotient
//                r     - remainder
//                dz    - divide-by-zero flag (only with DIV_ZERO_EN)
//  Macro       : DIV_ZERO_EN adds the dz signal to both modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             run;
  logic             u;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             stall;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
`ifdef DIV_ZERO_EN
  logic             dz;

  modport master (output run, u, x, y, input  stall, q, r, dz);
  modport slave  (input  run, u, x, y, output stall, q, r, dz);
`else
  modport master (output run, u, x, y, input  stall, q, r);
  modport slave  (input  run, u, x, y, output stall, q, r);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative restoring divider for the execute stage. One
//                quotient bit per cycle, MSB first. Signed mode gives a
//                floored quotient and a non-negative remainder (Oberon
//                DIV/MOD). Shares the run/stall handshake with the multiplier.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active high
//                bus  - seq_divider_if.slave (run, u, x, y, stall, q, r[, dz])
//  Parameters  : WIDTH - operand/result width
//                CW    - step counter width, 2**CW > WIDTH+1
//  Macro       : DIV_ZERO_EN - a zero divisor short-cuts straight to DONE
//                with q = all ones, r = raw x and the registered dz flag set.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input wire logic     clk,
  input wire logic     rst,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] den_q,   den_d;    // latched divisor
  logic [WIDTH-1:0] prem_q,  prem_d;   // partial remainder, always < divisor
  logic             neg_q,   neg_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
`ifdef DIV_ZERO_EN
  logic             dz_q,    dz_d;
`endif

  logic [WIDTH:0]   shifted;
  logic             borrow;
  logic [WIDTH-1:0] x_abs;
  logic             y_zero;

  // The shifted remainder can reach 2*y-1, hence one extra bit. When the
  // trial subtraction succeeds the difference is < y, so WIDTH bits suffice.
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign borrow  = (shifted < {1'b0, den_q});
  assign x_abs   = (!bus.u && bus.x[WIDTH-1]) ? ((~bus.x) + ONE) : bus.x;

`ifdef DIV_ZERO_EN
  assign y_zero = (bus.y == '0);
`else
  assign y_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    den_d   = den_q;
    prem_d  = prem_q;
    neg_d   = neg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          if (y_zero) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = bus.x;
`ifdef DIV_ZERO_EN
            dz_d    = 1'b1;
`endif
          end else begin
            state_d = S_BUSY;
            dvd_d   = x_abs;
            den_d   = bus.y;
            neg_d   = ~bus.u & bus.x[WIDTH-1];
            prem_d  = '0;
            count_d = '0;
          end
        end
      end

      S_BUSY: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else begin
          prem_d  = borrow ? shifted[WIDTH-1:0] : (shifted[WIDTH-1:0] - den_q);
          dvd_d   = {dvd_q[WIDTH-2:0], ~borrow};
          count_d = count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (!bus.run) begin
          state_d = S_IDLE;
        end else begin
          // Floored correction for a negative dividend: a non-zero remainder
          // pushes the quotient one further from zero and flips the remainder
          // into [0, y).
          if (!neg_q) begin
            quo_d = dvd_q;
            rem_d = prem_q;
          end else if (prem_q != '0) begin
            quo_d = ~dvd_q;
            rem_d = den_q - prem_q;
          end else begin
            quo_d = (~dvd_q) + ONE;
            rem_d = '0;
          end
`ifdef DIV_ZERO_EN
          dz_d    = 1'b0;
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      den_q   <= '0;
      prem_q  <= '0;
      neg_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      den_q   <= den_d;
      prem_q  <= prem_d;
      neg_q   <= neg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Combinational so the core sees the release in the same cycle as DONE.
  assign bus.stall = bus.run & (state_q != S_DONE);
  assign bus.q     = quo_q;
  assign bus.r     = rem_q;
`ifdef DIV_ZERO_EN
  assign bus.dz    = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider. Directed corner cases
//                plus randomized divides compared against an arithmetic
//                reference (64-bit integer division with floored correction).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic clk;
  logic rst;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH), .CW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_q  = '0;
  logic [31:0] last_r  = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, then floored so the remainder is
  // non-negative. A zero divisor yields all ones and the raw dividend.
  function automatic void model(input logic iu, input logic [31:0] ix, input logic [31:0] iy,
                                output logic [31:0] mq, output logic [31:0] mr);
    longint xs, yv, qq, rr;
    if (iy == 32'd0) begin
      mq = '1;
      mr = ix;
      return;
    end
    yv = longint'({32'd0, iy});
    xs = iu ? longint'({32'd0, ix}) : longint'($signed(ix));
    qq = xs / yv;
    rr = xs - qq * yv;
    if (rr < 0) begin
      qq = qq - 1;
      rr = rr + yv;
    end
    mq = qq[31:0];
    mr = rr[31:0];
  endfunction

  // Called at a negedge; issues one divide, waits for the stall release and
  // checks latency and results. With hold=1 run stays high afterwards so the
  // next call forms a back-to-back request.
  task automatic run_div(input logic iu, input logic [31:0] ix, input logic [31:0] iy,
                         input bit hold, input string tag);
    int          n;
    int          exp_lat;
    logic [31:0] eq, er;
    model(iu, ix, iy, eq, er);
    exp_lat = LAT;
`ifdef DIV_ZERO_EN
    if (iy == 32'd0) exp_lat = 1;
`endif
    bus.run = 1'b1;
    bus.u   = iu;
    bus.x   = ix;
    bus.y   = iy;
    n = 0;
    #1;
    while (bus.stall && n < 200) begin
      @(negedge clk);
      n++;
      // Operand changes after the load must not disturb the divide.
      if (n == 5) begin
        bus.u = ~iu;
        bus.x = $urandom;
        bus.y = $urandom;
      end
      #1;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_q"}, bus.q, eq);
    check_eq({tag, "_r"}, bus.r, er);
`ifdef DIV_ZERO_EN
    check_eq({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, (iy == 32'd0)});
`endif
    last_q = eq;
    last_r = er;
    @(negedge clk);
    if (!hold) bus.run = 1'b0;
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic        ru;
    bit          rh;

    rst     = 1'b1;
    bus.run = 1'b0;
    bus.u   = 1'b0;
    bus.x   = '0;
    bus.y   = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_q", bus.q, 32'd0);
    check_eq("reset_r", bus.r, 32'd0);
    check_eq("reset_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corners
    run_div(1'b1, 32'd100,       32'd7, 1'b0, "u100_7");
    run_div(1'b0, 32'hFFFFFFF9,  32'd2, 1'b0, "sm7_2");
    run_div(1'b0, 32'hFFFFFFF8,  32'd2, 1'b0, "sm8_2");
    run_div(1'b0, 32'h80000000,  32'd3, 1'b0, "smin_3");
    run_div(1'b1, 32'hFFFFFFFF,  32'd1, 1'b0, "umax_1");
    run_div(1'b0, 32'h00000005,  32'h80000001, 1'b0, "s_bigy");
    run_div(1'b1, 32'd5,         32'd0, 1'b0, "u5_0");
    run_div(1'b1, 32'd100,       32'd7, 1'b0, "after_zero");
    check_eq("explicit_q", bus.q, 32'd14);
    check_eq("explicit_r", bus.r, 32'd2);

    // Back-to-back with run held high: one-cycle release per divide
    run_div(1'b1, 32'd100, 32'd7, 1'b1, "b2b_a");
    run_div(1'b1, 32'd9,   32'd3, 1'b0, "b2b_b");

    // Abort mid-BUSY: results must keep the previous divide's values
    bus.run = 1'b1; bus.u = 1'b1; bus.x = 32'd1000; bus.y = 32'd9;
    repeat (10) @(negedge clk);
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("abort_stall", {31'd0, bus.stall}, 32'd0);
    check_eq("abort_q", bus.q, last_q);
    check_eq("abort_r", bus.r, last_r);
    run_div(1'b1, 32'd100, 32'd7, 1'b0, "reissue");

    // Reset mid-BUSY
    bus.run = 1'b1; bus.u = 1'b1; bus.x = 32'd9; bus.y = 32'd3;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    bus.run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_q", bus.q, 32'd0);
    check_eq("rst_r", bus.r, 32'd0);
    @(negedge clk);
    run_div(1'b0, 32'hFFFFFF9C, 32'd7, 1'b0, "post_rst");

    // Randomized divides
    for (int i = 0; i < 40; i++) begin
      ru = 1'($urandom_range(0, 1));
      rx = $urandom;
      if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
      if ($urandom_range(0, 1) == 1) ry = 32'($urandom_range(1, 50));
      else                           ry = $urandom;
      if (ry == 32'd0) ry = 32'd1;
      rh = bit'($urandom_range(0, 1));
      run_div(ru, rx, ry, rh, "rand");
    end
    bus.run = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
